// File: rtl/instr_mem_arbiter_if.sv
// instr_mem_arbiter_if: per-core fetch channels plus the shared instruction-memory port.
// Revision: 1.0
`default_nettype none

interface instr_mem_arbiter_if #(
    parameter int num_cores_p = 2
);
    logic [num_cores_p-1:0]       core_valid_i;
    logic [num_cores_p-1:0]       core_ready_o;
    logic [num_cores_p-1:0][31:0] core_addr_i;
    logic [num_cores_p-1:0]       core_valid_o;
    logic [num_cores_p-1:0][31:0] core_rdata_o;
    logic                         mem_valid_o;
    logic                         mem_ready_i;
    logic [31:0]                  mem_addr_o;
    logic                         mem_valid_i;
    logic [31:0]                  mem_rdata_i;
    logic                         err_o;

    modport slave (
        input  core_valid_i, core_addr_i, mem_ready_i, mem_valid_i, mem_rdata_i,
        output core_ready_o, core_valid_o, core_rdata_o, mem_valid_o, mem_addr_o, err_o
    );

    modport master (
        output core_valid_i, core_addr_i, mem_ready_i, mem_valid_i, mem_rdata_i,
        input  core_ready_o, core_valid_o, core_rdata_o, mem_valid_o, mem_addr_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
// instr_mem_arbiter: round-robin fetch arbiter with in-order ID FIFO for response steering.
// Optional macro INSTR_ARB_FIXED_PRIO_EN selects fixed priority (lowest core wins).
// Revision: 1.0
`default_nettype none

module instr_mem_arbiter #(
    parameter int num_cores_p       = 2,
    parameter int max_outstanding_p = 4
) (
    input  wire logic            clk_i,
    input  wire logic            nreset_i,
    instr_mem_arbiter_if.slave   bus
);
    localparam int IDW = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
    localparam int PW  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int CW  = $clog2(max_outstanding_p + 1);
    localparam logic [CW-1:0]  C_FULL     = CW'(max_outstanding_p);
    localparam logic [PW-1:0]  C_PTR_LAST = PW'(max_outstanding_p - 1);
    localparam logic [IDW-1:0] C_ID_LAST  = IDW'(num_cores_p - 1);
    localparam logic [IDW:0]   C_NCORES   = (IDW+1)'(num_cores_p);

    logic [IDW-1:0] search_base;
    logic [IDW-1:0] grant;
    logic [IDW:0]   cand;
    logic           found;
    logic           lock_q;
    logic [IDW-1:0] lock_id_q;
    logic           req_valid;
    logic           full;
    logic           push;
    logic           pop;
    logic [IDW-1:0] head;
    logic [num_cores_p-1:0] resp_onehot;

    logic [IDW-1:0] fifo_mem [max_outstanding_p];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic [num_cores_p-1:0] resp_valid_q;
    logic [31:0]    rdata_q;
    logic           err_q;

`ifdef INSTR_ARB_FIXED_PRIO_EN
    assign search_base = '0;
`else
    logic [IDW-1:0] rr_q;
    assign search_base = rr_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            rr_q <= '0;
        end else if (push) begin
            rr_q <= (grant == C_ID_LAST) ? '0 : grant + IDW'(1);
        end
    end
`endif

    // A pending (locked) grant overrides the search so the address stays stable.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < num_cores_p; i++) begin
            cand = {1'b0, search_base} + (IDW+1)'(i);
            if (cand >= C_NCORES) cand = cand - C_NCORES;
            if (!found && bus.core_valid_i[cand[IDW-1:0]]) begin
                grant = cand[IDW-1:0];
                found = 1'b1;
            end
        end
        if (lock_q) grant = lock_id_q;
    end

    assign full      = (count_q == C_FULL);
    assign req_valid = nreset_i & ~full & (|bus.core_valid_i);
    assign push      = req_valid & bus.mem_ready_i;
    assign pop       = bus.mem_valid_i & (count_q != '0);
    assign head      = fifo_mem[rd_ptr_q];

    assign bus.mem_valid_o = req_valid;
    assign bus.mem_addr_o  = bus.core_addr_i[grant];
    assign bus.core_valid_o = resp_valid_q;
    assign bus.err_o        = err_q;

    always_comb begin
        bus.core_ready_o = '0;
        resp_onehot      = '0;
        for (int c = 0; c < num_cores_p; c++) begin
            bus.core_ready_o[c] = push && (grant == IDW'(c));
            resp_onehot[c]      = pop && (head == IDW'(c));
            bus.core_rdata_o[c] = rdata_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= grant;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_valid_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (push) begin
                lock_q <= 1'b0;
            end else if (req_valid) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant;
            end

            if (push) wr_ptr_q <= (wr_ptr_q == C_PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == C_PTR_LAST) ? '0 : rd_ptr_q + PW'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            resp_valid_q <= resp_onehot;
            if (pop) rdata_q <= bus.mem_rdata_i;
            if (bus.mem_valid_i && count_q == '0) err_q <= 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
// tb_instr_mem_arbiter: directed scenarios plus randomized traffic against a queue-based model.
// Revision: 1.0
`default_nettype none

module tb_instr_mem_arbiter;
    localparam int NC    = 2;
    localparam int DEPTH = 4;
`ifdef INSTR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    instr_mem_arbiter_if #(.num_cores_p(NC)) bus ();

    instr_mem_arbiter #(.num_cores_p(NC), .max_outstanding_p(DEPTH)) dut (
        .clk_i   (clk),
        .nreset_i(nreset),
        .bus     (bus)
    );

    int total  = 0;
    int passed = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.core_valid_i = '0;
        bus.core_addr_i  = '0;
        bus.mem_ready_i  = 1'b0;
        bus.mem_valid_i  = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic do_reset;
        nreset = 1'b0;
        idle_inputs();
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic test_reset;
        tick();
        nreset = 1'b0;
        bus.core_valid_i = 2'b11;
        bus.mem_ready_i  = 1'b1;
        #1;
        total++; if (bus.mem_valid_o !== 1'b0) $display("FAIL reset_mem_valid got=%b exp=0", bus.mem_valid_o); else passed++;
        total++; if (bus.core_ready_o !== 2'b00) $display("FAIL reset_core_ready got=%b exp=00", bus.core_ready_o); else passed++;
        total++; if (bus.core_valid_o !== 2'b00) $display("FAIL reset_core_valid got=%b exp=00", bus.core_valid_o); else passed++;
        total++; if (bus.core_rdata_o[0] !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", bus.core_rdata_o[0]); else passed++;
        total++; if (bus.err_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.err_o); else passed++;
        do_reset();
    endtask

    task automatic test_single_core;
        do_reset();
        bus.core_valid_i   = 2'b01;
        bus.core_addr_i[0] = 32'h100;
        bus.mem_ready_i    = 1'b1;
        #4;
        total++; if (bus.core_ready_o !== 2'b01) $display("FAIL single_ready got=%b exp=01", bus.core_ready_o); else passed++;
        total++; if (bus.mem_addr_o !== 32'h100) $display("FAIL single_addr got=%h exp=100", bus.mem_addr_o); else passed++;
        tick();
        bus.core_valid_i = '0;
        bus.mem_ready_i  = 1'b0;
        tick();
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = 32'hDEADBEEF;
        #4;
        total++; if (bus.core_valid_o !== 2'b00) $display("FAIL single_early_strobe got=%b exp=00", bus.core_valid_o); else passed++;
        tick();
        bus.mem_valid_i = 1'b0;
        total++; if (bus.core_valid_o !== 2'b01) $display("FAIL single_resp_valid got=%b exp=01", bus.core_valid_o); else passed++;
        total++; if (bus.core_rdata_o[0] !== 32'hDEADBEEF) $display("FAIL single_rdata0 got=%h exp=deadbeef", bus.core_rdata_o[0]); else passed++;
        total++; if (bus.core_rdata_o[1] !== 32'hDEADBEEF) $display("FAIL single_rdata1 got=%h exp=deadbeef", bus.core_rdata_o[1]); else passed++;
        tick();
        total++; if (bus.core_valid_o !== 2'b00) $display("FAIL single_strobe_len got=%b exp=00", bus.core_valid_o); else passed++;
    endtask

    task automatic test_round_robin;
        int exp_id;
        do_reset();
        bus.core_valid_i   = 2'b11;
        bus.core_addr_i[0] = 32'h1000;
        bus.core_addr_i[1] = 32'h2000;
        bus.mem_ready_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = FIXED ? 0 : (i % 2);
            #4;
            total++; if (bus.core_ready_o !== NC'(1 << exp_id)) $display("FAIL rr_grant%0d got=%b exp=%b", i, bus.core_ready_o, NC'(1 << exp_id)); else passed++;
            total++; if (bus.mem_addr_o !== (exp_id == 1 ? 32'h2000 : 32'h1000)) $display("FAIL rr_addr%0d got=%h", i, bus.mem_addr_o); else passed++;
            tick();
        end
        bus.core_valid_i = '0;
        bus.mem_ready_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_id = FIXED ? 0 : (i % 2);
            bus.mem_valid_i = 1'b1;
            bus.mem_rdata_i = 32'h50 + 32'(i);
            tick();
            total++; if (bus.core_valid_o !== NC'(1 << exp_id)) $display("FAIL rr_resp%0d got=%b exp=%b", i, bus.core_valid_o, NC'(1 << exp_id)); else passed++;
            total++; if (bus.core_rdata_o[exp_id] !== 32'h50 + 32'(i)) $display("FAIL rr_rdata%0d got=%h", i, bus.core_rdata_o[exp_id]); else passed++;
        end
        bus.mem_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_lock;
        do_reset();
        bus.core_valid_i   = 2'b10;
        bus.core_addr_i[1] = 32'h200;
        bus.core_addr_i[0] = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #4;
            total++; if (bus.mem_valid_o !== 1'b1 || bus.mem_addr_o !== 32'h200) $display("FAIL lock_wait%0d got=%b/%h exp=1/200", i, bus.mem_valid_o, bus.mem_addr_o); else passed++;
            tick();
        end
        bus.core_valid_i = 2'b11;
        #4;
        total++; if (bus.mem_addr_o !== 32'h200 || bus.core_ready_o !== 2'b00) $display("FAIL lock_hold got=%h/%b exp=200/00", bus.mem_addr_o, bus.core_ready_o); else passed++;
        tick();
        bus.mem_ready_i = 1'b1;
        #4;
        total++; if (bus.core_ready_o !== 2'b10) $display("FAIL lock_grant1 got=%b exp=10", bus.core_ready_o); else passed++;
        tick();
        bus.core_valid_i = 2'b01;
        #4;
        total++; if (bus.core_ready_o !== 2'b01 || bus.mem_addr_o !== 32'h300) $display("FAIL lock_grant0 got=%b/%h exp=01/300", bus.core_ready_o, bus.mem_addr_o); else passed++;
        tick();
        idle_inputs();
    endtask

    task automatic test_full;
        int exp_id;
        do_reset();
        bus.core_valid_i   = 2'b11;
        bus.core_addr_i[0] = 32'hA000;
        bus.core_addr_i[1] = 32'hB000;
        bus.mem_ready_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4;
            total++; if (bus.mem_valid_o !== 1'b1) $display("FAIL full_fill%0d got=%b exp=1", i, bus.mem_valid_o); else passed++;
            tick();
        end
        #4;
        total++; if (bus.mem_valid_o !== 1'b0 || bus.core_ready_o !== 2'b00) $display("FAIL full_stall got=%b/%b exp=0/00", bus.mem_valid_o, bus.core_ready_o); else passed++;
        tick();
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = 32'hA0;
        #4;
        total++; if (bus.mem_valid_o !== 1'b0) $display("FAIL full_pop_same_cycle got=%b exp=0", bus.mem_valid_o); else passed++;
        tick();
        bus.mem_valid_i = 1'b0;
        total++; if (bus.core_valid_o !== 2'b01) $display("FAIL full_first_resp got=%b exp=01", bus.core_valid_o); else passed++;
        #4;
        total++; if (bus.mem_valid_o !== 1'b1 || bus.core_ready_o !== 2'b01) $display("FAIL full_resume got=%b/%b exp=1/01", bus.mem_valid_o, bus.core_ready_o); else passed++;
        tick();
        bus.core_valid_i = '0;
        bus.mem_ready_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_id = FIXED ? 0 : ((i % 2 == 0) ? 1 : 0);
            bus.mem_valid_i = 1'b1;
            bus.mem_rdata_i = 32'hB0 + 32'(i);
            tick();
            total++; if (bus.core_valid_o !== NC'(1 << exp_id)) $display("FAIL full_order%0d got=%b exp=%b", i, bus.core_valid_o, NC'(1 << exp_id)); else passed++;
        end
        bus.mem_valid_i = 1'b0;
        tick();
        total++; if (bus.core_valid_o !== 2'b00 || bus.err_o !== 1'b0) $display("FAIL full_drained got=%b/%b exp=00/0", bus.core_valid_o, bus.err_o); else passed++;
    endtask

    task automatic test_random;
        bit          req [NC];
        logic [31:0] raddr [NC];
        int          q [$];
        int          rr;
        bit          locked;
        int          lock_id;
        int          g;
        int          c;
        int          h;
        int          lane;
        bit          rdy;
        bit          mv_in;
        bit          exp_mv;
        logic [31:0] rd;
        logic [NC-1:0] exp_cv;
        logic [NC-1:0] exp_rdy;
        logic [31:0] exp_data;
        do_reset();
        rr = 0; locked = 0; lock_id = 0; exp_cv = '0; exp_data = '0;
        for (int k = 0; k < NC; k++) begin req[k] = 0; raddr[k] = '0; end
        for (int cyc = 0; cyc < 300; cyc++) begin
            total++; if (bus.core_valid_o !== exp_cv) $display("FAIL rnd_resp_valid cyc=%0d got=%b exp=%b", cyc, bus.core_valid_o, exp_cv); else passed++;
            if (exp_cv != '0) begin
                lane = $urandom_range(0, NC-1);
                total++; if (bus.core_rdata_o[lane] !== exp_data) $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.core_rdata_o[lane], exp_data); else passed++;
            end
            for (int k = 0; k < NC; k++) begin
                if (!req[k] && $urandom_range(0, 1) == 1) begin
                    req[k]   = 1;
                    raddr[k] = $urandom;
                end
                bus.core_valid_i[k] = req[k];
                bus.core_addr_i[k]  = raddr[k];
            end
            rdy   = ($urandom_range(0, 9) < 7);
            mv_in = (q.size() > 0) && ($urandom_range(0, 9) < 4);
            rd    = $urandom;
            bus.mem_ready_i = rdy;
            bus.mem_valid_i = mv_in;
            bus.mem_rdata_i = rd;

            g = -1;
            if (locked) g = lock_id;
            else for (int k = 0; k < NC; k++) begin
                c = ((FIXED ? 0 : rr) + k) % NC;
                if (g < 0 && req[c]) g = c;
            end
            exp_mv  = (g >= 0) && (q.size() < DEPTH);
            exp_rdy = (exp_mv && rdy) ? NC'(1 << g) : '0;
            #4;
            total++; if (bus.mem_valid_o !== exp_mv) $display("FAIL rnd_mem_valid cyc=%0d got=%b exp=%b", cyc, bus.mem_valid_o, exp_mv); else passed++;
            total++; if (bus.core_ready_o !== exp_rdy) $display("FAIL rnd_core_ready cyc=%0d got=%b exp=%b", cyc, bus.core_ready_o, exp_rdy); else passed++;
            if (exp_mv) begin
                total++; if (bus.mem_addr_o !== raddr[g]) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, bus.mem_addr_o, raddr[g]); else passed++;
            end

            exp_cv = '0;
            if (mv_in) begin
                h        = q.pop_front();
                exp_cv   = NC'(1 << h);
                exp_data = rd;
            end
            if (exp_mv && rdy) begin
                q.push_back(g);
                req[g] = 0;
                rr     = (g + 1) % NC;
                locked = 0;
            end else if (exp_mv) begin
                locked  = 1;
                lock_id = g;
            end
            tick();
        end
        total++; if (bus.err_o !== 1'b0) $display("FAIL rnd_err got=%b exp=0", bus.err_o); else passed++;
        idle_inputs();
    endtask

    task automatic test_error;
        do_reset();
        bus.mem_valid_i = 1'b1;
        bus.mem_rdata_i = 32'h1234;
        tick();
        bus.mem_valid_i = 1'b0;
        total++; if (bus.core_valid_o !== 2'b00) $display("FAIL err_no_strobe got=%b exp=00", bus.core_valid_o); else passed++;
        total++; if (bus.err_o !== 1'b1) $display("FAIL err_set got=%b exp=1", bus.err_o); else passed++;
        repeat (5) tick();
        total++; if (bus.err_o !== 1'b1) $display("FAIL err_sticky got=%b exp=1", bus.err_o); else passed++;
    endtask

    task automatic test_reset_mid_flight;
        do_reset();
        bus.core_valid_i   = 2'b01;
        bus.core_addr_i[0] = 32'h40;
        bus.core_addr_i[1] = 32'h80;
        bus.mem_ready_i    = 1'b1;
        tick();
        tick();
        bus.core_valid_i = '0;
        bus.mem_ready_i  = 1'b0;
        bus.mem_valid_i  = 1'b1;
        bus.mem_rdata_i  = 32'h77;
        tick();
        bus.mem_valid_i = 1'b0;
        total++; if (bus.core_valid_o !== 2'b01) $display("FAIL rmf_pre_strobe got=%b exp=01", bus.core_valid_o); else passed++;
        bus.core_valid_i = 2'b11;
        bus.mem_ready_i  = 1'b1;
        #2;
        nreset = 1'b0;
        #1;
        total++; if (bus.mem_valid_o !== 1'b0 || bus.core_ready_o !== 2'b00) $display("FAIL rmf_req_clear got=%b/%b exp=0/00", bus.mem_valid_o, bus.core_ready_o); else passed++;
        total++; if (bus.core_valid_o !== 2'b00 || bus.core_rdata_o[0] !== 32'h0) $display("FAIL rmf_resp_clear got=%b/%h exp=00/0", bus.core_valid_o, bus.core_rdata_o[0]); else passed++;
        tick();
        nreset = 1'b1;
        bus.mem_ready_i = 1'b0;
        #4;
        total++; if (bus.mem_addr_o !== 32'h40) $display("FAIL rmf_rr_cleared got=%h exp=40", bus.mem_addr_o); else passed++;
        tick();
        bus.core_valid_i = '0;
        bus.mem_valid_i  = 1'b1;
        tick();
        bus.mem_valid_i = 1'b0;
        total++; if (bus.err_o !== 1'b1 || bus.core_valid_o !== 2'b00) $display("FAIL rmf_fifo_empty got=%b/%b exp=1/00", bus.err_o, bus.core_valid_o); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_single_core();
        test_round_robin();
        test_lock();
        test_full();
        test_random();
        test_error();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

`default_nettype wire
